// File: rtl/conv_pkg.sv
// Shared definitions for the convolution-engine sequencer: state encoding,
// engine indices and result geometry.
package conv_pkg;

  localparam int DW      = 8;
  localparam int NUM_OUT = 4;

  localparam int ENG_SINGLE = 0;
  localparam int ENG_SYS3   = 1;
  localparam int ENG_SYS2   = 2;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RUN_E0  = 3'd1,
    S_RUN_E1  = 3'd2,
    S_RUN_E2  = 3'd3,
    S_DISPLAY = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  function automatic logic is_run_state(input state_t s);
    return (s == S_RUN_E0) || (s == S_RUN_E1) || (s == S_RUN_E2);
  endfunction

  // The RUN states are consecutive, so the engine index is an offset.
  function automatic logic [1:0] eng_of_state(input state_t s);
    return 2'(s - S_RUN_E0);
  endfunction

endpackage

// File: rtl/seq_timeout_counter.sv
// Wait counter for one engine run: clears, counts while enabled, saturates at
// TIMEOUT and flags the saturated value.
module seq_timeout_counter #(
  parameter int TIMEOUT = 255,
  localparam int CW = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_hit
);

  localparam logic [CW-1:0] MAX_COUNT = CW'(TIMEOUT);

  logic [CW-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and updates together.
  always_ff @(posedge clk) begin
    if (i_reset || i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != MAX_COUNT)) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign o_hit = (r_count == MAX_COUNT);

endmodule

// File: rtl/conv_engine_sequencer.sv
// Runs the single-MAC, systolic3 and systolic2 engines in turn, buffers their
// 2x2 results, cross-checks them against engine 0 and streams all 12 values.
module conv_engine_sequencer #(
  parameter int NUM_ENG = 3,
  parameter int DW      = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  run,
  output logic [NUM_ENG-1:0]                    eng_start,
  input  logic [NUM_ENG-1:0]                    eng_done,
  input  logic [NUM_ENG*conv_pkg::NUM_OUT*DW-1:0] eng_result,
  output logic [DW-1:0]                         display_result,
  output logic [2:0]                            display_current_state,
  output logic                                  busy,
  output logic [NUM_ENG-1:0]                    timeout_flag,
  output logic [NUM_ENG-1:0]                    mismatch
);

  import conv_pkg::*;

  localparam int NBUF = NUM_ENG * NUM_OUT;
  localparam int LAST = NBUF - 1;

  state_t             r_state;
  state_t             w_state_next;
  logic               r_entry;
  logic [DW-1:0]      r_buf      [NBUF];
  logic [DW-1:0]      w_buf_next [NBUF];
  logic [DW-1:0]      w_res      [NBUF];
  logic [NUM_ENG-1:0] r_timeout;
  logic [NUM_ENG-1:0] w_timeout_next;
  logic [NUM_ENG-1:0] r_mismatch;
  logic [NUM_ENG-1:0] w_mismatch_next;
  logic [3:0]         r_idx;
  logic [1:0]         w_eng;
  logic               w_in_run;
  logic               w_state_change;
  logic               w_hit;

  assign w_eng          = eng_of_state(r_state);
  assign w_in_run       = is_run_state(r_state);
  assign w_state_change = (w_state_next != r_state);

  always_comb begin
    for (int i = 0; i < NBUF; i++) begin
      w_res[i] = eng_result[i*DW +: DW];
    end
  end

  // Cleared on every state change, so each RUN state starts its wait at 0
  // in its start cycle.
  seq_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_counter (
    .clk      (clk),
    .i_reset  (reset),
    .i_clear  (w_state_change),
    .i_enable (w_in_run),
    .o_hit    (w_hit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_entry <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_entry <= w_state_change;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    w_state_next    = r_state;
    w_buf_next      = r_buf;
    w_timeout_next  = r_timeout;
    w_mismatch_next = r_mismatch;
    eng_start       = '0;

    unique case (r_state)
      S_IDLE: begin
        if (run) begin
          w_state_next    = S_RUN_E0;
          w_timeout_next  = '0;
          w_mismatch_next = '0;
        end
      end
      S_RUN_E0, S_RUN_E1, S_RUN_E2: begin
        // A done in the start cycle belongs to no request and is ignored.
        if (r_entry) begin
          eng_start[w_eng] = 1'b1;
        end else if (eng_done[w_eng]) begin
          for (int k = 0; k < NUM_OUT; k++) begin
            w_buf_next[w_eng*NUM_OUT + k] = w_res[w_eng*NUM_OUT + k];
          end
          w_state_next = state_t'(r_state + 3'd1);
        end else if (w_hit) begin
          for (int k = 0; k < NUM_OUT; k++) begin
            w_buf_next[w_eng*NUM_OUT + k] = '0;
          end
          w_timeout_next[w_eng] = 1'b1;
          w_state_next          = state_t'(r_state + 3'd1);
        end
      end
      S_DISPLAY: begin
        if (r_idx == 4'(LAST)) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (!run) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    // Compare on the buffer as it will be after engine 2 is written.
    if ((r_state == S_RUN_E2) && (w_state_next == S_DISPLAY)) begin
      for (int e = 0; e < NUM_ENG; e++) begin
        w_mismatch_next[e] = 1'b0;
        for (int k = 0; k < NUM_OUT; k++) begin
          w_mismatch_next[e] = w_mismatch_next[e] |
            (|(w_buf_next[e*NUM_OUT + k] ^ w_buf_next[ENG_SINGLE*NUM_OUT + k]));
        end
      end
    end

    if (reset) begin
      eng_start = '0;
    end
  end

  // NOTE: the result buffer is only twelve bytes and is reset explicitly, so
  // no stale results from an aborted job can ever be streamed.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_timeout  <= '0;
      r_mismatch <= '0;
      r_idx      <= '0;
      for (int i = 0; i < NBUF; i++) begin
        r_buf[i] <= '0;
      end
    end else begin
      r_timeout  <= w_timeout_next;
      r_mismatch <= w_mismatch_next;
      r_idx      <= ((r_state == S_DISPLAY) && (w_state_next == S_DISPLAY)) ?
                    r_idx + 4'd1 : 4'd0;
      for (int i = 0; i < NBUF; i++) begin
        r_buf[i] <= w_buf_next[i];
      end
    end
  end

  always_comb begin
    if (r_state == S_DISPLAY) begin
      display_result = r_buf[r_idx];
    end else if (r_state == S_DONE) begin
      display_result = r_buf[LAST];
    end else begin
      display_result = '0;
    end
  end

  assign display_current_state = r_state;
  assign busy                  = (r_state != S_IDLE) && (r_state != S_DONE);
  assign timeout_flag          = r_timeout;
  assign mismatch              = r_mismatch;

endmodule

// File: tb/tb_conv_engine_sequencer.sv
// Self-checking bench: engine responders, a job-level timeline model and a
// per-cycle compare, plus hand-computed pins at key cycles.
module tb_conv_engine_sequencer;

  localparam int NE = 3;
  localparam int W  = 8;
  localparam int N  = 4096;

  logic              clk = 1'b0;
  logic              reset;
  logic              run;
  logic [NE-1:0]     eng_start;
  logic [NE-1:0]     eng_done;
  logic [NE*4*W-1:0] eng_result;
  logic [W-1:0]      display_result;
  logic [2:0]        display_current_state;
  logic              busy;
  logic [NE-1:0]     timeout_flag;
  logic [NE-1:0]     mismatch;

  conv_engine_sequencer #(
    .NUM_ENG (NE),
    .DW      (W),
    .TIMEOUT (255)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .run                   (run),
    .eng_start             (eng_start),
    .eng_done              (eng_done),
    .eng_result            (eng_result),
    .display_result        (display_result),
    .display_current_state (display_current_state),
    .busy                  (busy),
    .timeout_flag          (timeout_flag),
    .mismatch              (mismatch)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Engine behaviour: dly = cycles from start to done (0 = never answers).
  int         dly  [NE];
  int         due  [NE];
  int         spur [NE];
  logic [7:0] val  [NE][4];

  // Expected outputs per cycle.
  logic       exp_valid [N];
  logic [2:0] exp_state [N];
  logic [2:0] exp_start [N];
  logic [7:0] exp_disp  [N];
  logic       exp_busy  [N];
  logic [2:0] exp_tmo   [N];
  logic [2:0] exp_mis   [N];
  logic [2:0] prev_tmo;
  logic [2:0] prev_mis;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic at_pos(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic at_neg(input int c);
    at_pos(c);
    @(negedge clk);
  endtask

  task automatic set_exp(input int c, input logic [2:0] st, input logic [2:0] stt,
                         input logic [7:0] d, input logic b, input logic [2:0] t,
                         input logic [2:0] m);
    if (c >= 0 && c < N) begin
      exp_valid[c] = 1'b1;
      exp_state[c] = st;
      exp_start[c] = stt;
      exp_disp[c]  = d;
      exp_busy[c]  = b;
      exp_tmo[c]   = t;
      exp_mis[c]   = m;
    end
  endtask

  // Timeline of one job launched by run=1 sampled in IDLE at cycle t0.
  task automatic plan_job(input int t0, input int hold, output int td);
    int         t;
    int         l;
    logic       to;
    logic [2:0] tmo;
    logic [2:0] mis;
    logic [7:0] lat [12];
    set_exp(t0, 3'd0, 3'b000, 8'd0, 1'b0, prev_tmo, prev_mis);
    t   = t0 + 1;
    tmo = 3'b000;
    for (int e = 0; e < NE; e++) begin
      to = !(dly[e] >= 1 && dly[e] <= 255);
      l  = to ? 256 : dly[e] + 1;
      for (int k = 0; k < 4; k++) lat[e*4+k] = to ? 8'd0 : val[e][k];
      for (int c = 0; c < l; c++)
        set_exp(t + c, 3'(e + 1), (c == 0) ? 3'(1 << e) : 3'b000, 8'd0, 1'b1, tmo, 3'b000);
      if (to) tmo[e] = 1'b1;
      t += l;
    end
    for (int e = 0; e < NE; e++) begin
      mis[e] = 1'b0;
      for (int k = 0; k < 4; k++) if (lat[e*4+k] != lat[k]) mis[e] = 1'b1;
    end
    for (int i = 0; i < 12; i++) set_exp(t + i, 3'd4, 3'b000, lat[i], 1'b1, tmo, mis);
    t += 12;
    for (int i = 0; i < hold; i++) set_exp(t + i, 3'd5, 3'b000, lat[11], 1'b0, tmo, mis);
    td = t + hold - 1;
    set_exp(td + 1, 3'd0, 3'b000, 8'd0, 1'b0, tmo, mis);
    prev_tmo = tmo;
    prev_mis = mis;
  endtask

  task automatic start_job(input int hold, output int t0, output int td);
    t0 = cyc;
    plan_job(t0, hold, td);
    run = 1'b1;
  endtask

  task automatic finish_job(input int td);
    at_pos(td);
    run = 1'b0;
    at_pos(td + 2);
  endtask

  task automatic set_vals(input int e, input logic [7:0] v0, input logic [7:0] v1,
                          input logic [7:0] v2, input logic [7:0] v3);
    val[e][0] = v0;
    val[e][1] = v1;
    val[e][2] = v2;
    val[e][3] = v3;
  endtask

  // Engine responders: result bus carries garbage except in the done cycle.
  always @(negedge clk) begin
    for (int e = 0; e < NE; e++)
      if (eng_start[e] === 1'b1 && dly[e] != 0) due[e] = cyc + dly[e];
  end

  always begin
    @(posedge clk);
    #1;
    for (int e = 0; e < NE; e++) begin
      eng_done[e] = (cyc == due[e]) || (cyc == spur[e]);
      for (int k = 0; k < 4; k++)
        eng_result[(e*4+k)*W +: W] = (cyc == due[e]) ? val[e][k] : 8'hEE;
    end
  end

  always @(negedge clk) begin
    if (cyc < N && exp_valid[cyc]) begin
      check("state", 32'(display_current_state), 32'(exp_state[cyc]));
      check("eng_start", 32'(eng_start), 32'(exp_start[cyc]));
      check("display", 32'(display_result), 32'(exp_disp[cyc]));
      check("busy", 32'(busy), 32'(exp_busy[cyc]));
      check("timeout_flag", 32'(timeout_flag), 32'(exp_tmo[cyc]));
      check("mismatch", 32'(mismatch), 32'(exp_mis[cyc]));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog cycle=%0d got=running expected=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0;
    int td;
    int r;
    reset      = 1'b1;
    run        = 1'b0;
    eng_done   = '0;
    eng_result = '0;
    prev_tmo   = 3'b000;
    prev_mis   = 3'b000;
    for (int i = 0; i < N; i++) exp_valid[i] = 1'b0;
    for (int e = 0; e < NE; e++) begin
      dly[e]  = 1;
      due[e]  = -10;
      spur[e] = -10;
    end
    for (int c = 1; c <= 4; c++) set_exp(c, 3'd0, 3'b000, 8'd0, 1'b0, 3'b000, 3'b000);

    at_neg(2);
    check("reset_state", 32'(display_current_state), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    at_pos(3);
    reset = 1'b0;
    at_pos(5);

    // Job 1: all engines agree.
    dly[0] = 3; dly[1] = 4; dly[2] = 2;
    for (int e = 0; e < NE; e++) set_vals(e, 8'd110, 8'd101, 8'd110, 8'd121);
    start_job(1, t0, td);
    at_neg(t0 + 13);
    check("j1_first_display", 32'(display_result), 32'd110);
    at_neg(t0 + 24);
    check("j1_last_display", 32'(display_result), 32'd121);
    at_neg(t0 + 25);
    check("j1_done_state", 32'(display_current_state), 32'd5);
    check("j1_mismatch", 32'(mismatch), 32'd0);
    finish_job(td);

    // Job 2: engine 2 never answers.
    dly[0] = 3; dly[1] = 2; dly[2] = 0;
    start_job(1, t0, td);
    at_neg(t0 + 263);
    check("j2_e2_cycle256_state", 32'(display_current_state), 32'd3);
    at_neg(t0 + 264);
    check("j2_timeout_flag", 32'(timeout_flag), 32'b100);
    check("j2_mismatch", 32'(mismatch), 32'b100);
    check("j2_first_display", 32'(display_result), 32'd110);
    at_neg(t0 + 272);
    check("j2_e2_zero", 32'(display_result), 32'd0);
    finish_job(td);

    // Job 3: engine 1 disagrees; run held through DONE for 20 cycles.
    dly[0] = 2; dly[1] = 3; dly[2] = 1;
    set_vals(0, 8'd50, 8'd127, 8'd137, 8'd121);
    set_vals(1, 8'd248, 8'd3, 8'd137, 8'd121);
    set_vals(2, 8'd50, 8'd127, 8'd137, 8'd121);
    start_job(20, t0, td);
    at_neg(t0);
    check("j3_flags_held_idle", 32'(timeout_flag), 32'b100);
    at_neg(t0 + 1);
    check("j3_flags_cleared", 32'(timeout_flag), 32'd0);
    at_neg(t0 + 14);
    check("j3_e1_c11", 32'(display_result), 32'd248);
    at_neg(t0 + 41);
    check("j3_done_hold_state", 32'(display_current_state), 32'd5);
    check("j3_mismatch", 32'(mismatch), 32'b010);
    finish_job(td);

    // Job 4: reset in the first cycle of RUN_E1.
    dly[0] = 2; dly[1] = 50; dly[2] = 2;
    start_job(1, t0, td);
    at_neg(t0 + 1);
    check("j4_mismatch_cleared", 32'(mismatch), 32'd0);
    r = t0 + 4;
    at_pos(r);
    reset = 1'b1;
    run   = 1'b0;
    exp_start[r] = 3'b000;
    for (int c = r + 1; c <= r + 2; c++) set_exp(c, 3'd0, 3'b000, 8'd0, 1'b0, 3'b000, 3'b000);
    for (int c = r + 3; c <= td + 1 && c < N; c++) exp_valid[c] = 1'b0;
    prev_tmo = 3'b000;
    prev_mis = 3'b000;
    at_neg(r);
    check("j4_no_start_in_reset", 32'(eng_start), 32'd0);
    at_pos(r + 1);
    reset = 1'b0;
    at_neg(r + 1);
    check("j4_after_reset_state", 32'(display_current_state), 32'd0);
    check("j4_after_reset_busy", 32'(busy), 32'd0);
    at_pos(r + 3);

    // Job 5: stray done from engine 1 during RUN_E0; engine 1 answers at 255.
    dly[0] = 5; dly[1] = 255; dly[2] = 3;
    set_vals(0, 8'd1, 8'd2, 8'd3, 8'd4);
    set_vals(1, 8'd1, 8'd2, 8'd3, 8'd4);
    set_vals(2, 8'd9, 8'd2, 8'd3, 8'd4);
    spur[1] = cyc + 3;
    start_job(1, t0, td);
    at_neg(t0 + 4);
    check("j5_stray_done_ignored", 32'(display_current_state), 32'd1);
    at_neg(t0 + 267);
    check("j5_done_wins_no_flag", 32'(timeout_flag), 32'd0);
    check("j5_mismatch", 32'(mismatch), 32'b100);
    check("j5_first_display", 32'(display_result), 32'd1);
    spur[1] = -10;
    finish_job(td);

    // Job 6: clean repeat of job 1.
    dly[0] = 3; dly[1] = 4; dly[2] = 2;
    for (int e = 0; e < NE; e++) set_vals(e, 8'd110, 8'd101, 8'd110, 8'd121);
    start_job(3, t0, td);
    at_neg(t0 + 13);
    check("j6_first_display", 32'(display_result), 32'd110);
    finish_job(td);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
